// File: rtl/display_scan.sv
// Time-multiplexed scan driver for a common-anode seven-segment display.
// Holds the value as hex nibbles, refreshes one digit per slot, updates only at frame boundaries.
module display_scan #(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned DIV    = 100000
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic [4*DIGITS-1:0]   iData,
  input  logic                  iLoad,
  input  logic                  iBlankLZ,
  output logic [3:0]            oDigit,
  output logic [DIGITS-1:0]     oAnode,
  output logic                  oFrame
);

  localparam int unsigned DATA_W = 4 * DIGITS;
  localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [IDX_W-1:0]  idx_q,     idx_d;
  logic [DATA_W-1:0] shadow_q,  shadow_d;
  logic [DATA_W-1:0] pending_q, pending_d;
  logic              pend_v_q,  pend_v_d;
  logic              blz_q,     blz_d;
  logic              frame_q,   frame_d;

  logic              tick_c;
  logic              wrap_c;
  logic [DIGITS-1:0] blank_c;

  // Prescaler, digit index and frame-boundary value/blanking updates
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    pend_v_d  = pend_v_q;
    blz_d     = blz_q;
    tick_c    = (cnt_q == CNT_MAX);
    wrap_c    = tick_c && (idx_q == IDX_MAX);
    frame_d   = wrap_c;

    if (tick_c) begin
      cnt_d = '0;
      idx_d = wrap_c ? '0 : idx_q + IDX_W'(1);
    end

    if (wrap_c) begin
      blz_d = iBlankLZ;
      // A load landing on the wrap itself wins over anything still pending
      if (iLoad) begin
        shadow_d = iData;
        pend_v_d = 1'b0;
      end else if (pend_v_q) begin
        shadow_d = pending_q;
        pend_v_d = 1'b0;
      end
    end else if (iLoad) begin
      pending_d = iData;
      pend_v_d  = 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      pending_q <= '0;
      pend_v_q  <= 1'b0;
      blz_q     <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      pend_v_q  <= pend_v_d;
      blz_q     <= blz_d;
      frame_q   <= frame_d;
    end
  end

  // Leading-zero mask: digit i blanks when every nibble from the top down to i is zero
  always_comb begin
    logic all_zero;
    blank_c  = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero   = all_zero && (shadow_q[4*i +: 4] == 4'h0);
      blank_c[i] = blz_q && all_zero;
    end
  end

  // Digit mux and anode decode from registered state only
  always_comb begin
    oDigit = 4'h0;
    oAnode = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        oDigit = shadow_q[4*i +: 4];
        if (!blank_c[i]) begin
          oAnode[i] = 1'b0;
        end
      end
    end
  end

  assign oFrame = frame_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with DIGITS=8, DIV=4: vector table plus a mid-frame reset sequence.
module tb_display_scan;

  logic        iClk;
  logic        iRst_n;
  logic [31:0] iData;
  logic        iLoad;
  logic        iBlankLZ;
  logic [3:0]  oDigit;
  logic [7:0]  oAnode;
  logic        oFrame;

  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned cyc;

  typedef struct {
    bit          rst;
    int unsigned cyc;
    bit          ld;
    logic [31:0] data;
    bit          blz;
    logic [7:0]  an;
    logic [3:0]  dg;
    bit          fr;
  } vec_t;

  vec_t vecs[$];

  display_scan #(.DIGITS(8), .DIV(4)) dut (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .iData    (iData),
    .iLoad    (iLoad),
    .iBlankLZ (iBlankLZ),
    .oDigit   (oDigit),
    .oAnode   (oAnode),
    .oFrame   (oFrame)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void add(input bit rst, input int unsigned c, input bit ld,
                              input logic [31:0] data, input bit blz,
                              input logic [7:0] an, input logic [3:0] dg, input bit fr);
    vec_t v;
    v.rst = rst; v.cyc = c; v.ld = ld; v.data = data; v.blz = blz;
    v.an = an; v.dg = dg; v.fr = fr;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
    end
  endtask

  task automatic tick_edge();
    @(posedge iClk);
    #1;
    cyc++;
    iLoad = 1'b0;
  endtask

  task automatic do_reset();
    iRst_n   = 1'b0;
    iLoad    = 1'b0;
    iData    = '0;
    iBlankLZ = 1'b0;
    @(negedge iClk);
    iRst_n = 1'b1;
    #1;
    cyc = 0;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    cyc      = 0;
    iRst_n   = 1'b0;
    iLoad    = 1'b0;
    iData    = '0;
    iBlankLZ = 1'b0;

    // Free-running scan after reset
    add(1,  0, 0, 0, 0, 8'hFE, 4'h0, 0);
    add(0,  3, 0, 0, 0, 8'hFE, 4'h0, 0);
    add(0,  4, 0, 0, 0, 8'hFD, 4'h0, 0);
    add(0,  8, 0, 0, 0, 8'hFB, 4'h0, 0);
    add(0, 12, 0, 0, 0, 8'hF7, 4'h0, 0);
    add(0, 16, 0, 0, 0, 8'hEF, 4'h0, 0);
    add(0, 20, 0, 0, 0, 8'hDF, 4'h0, 0);
    add(0, 24, 0, 0, 0, 8'hBF, 4'h0, 0);
    add(0, 28, 0, 0, 0, 8'h7F, 4'h0, 0);
    add(0, 31, 0, 0, 0, 8'h7F, 4'h0, 0);
    add(0, 32, 0, 0, 0, 8'hFE, 4'h0, 1);
    add(0, 33, 0, 0, 0, 8'hFE, 4'h0, 0);
    add(0, 36, 0, 0, 0, 8'hFD, 4'h0, 0);
    add(0, 40, 0, 0, 0, 8'hFB, 4'h0, 0);
    add(0, 63, 0, 0, 0, 8'h7F, 4'h0, 0);
    add(0, 64, 0, 0, 0, 8'hFE, 4'h0, 1);
    // Mid-frame load captured at edge 10, shown from the wrap
    add(1,  0, 0, 0, 0, 8'hFE, 4'h0, 0);
    add(0,  9, 1, 32'h87654321, 0, 8'hFB, 4'h0, 0);
    add(0, 12, 0, 0, 0, 8'hF7, 4'h0, 0);
    add(0, 31, 0, 0, 0, 8'h7F, 4'h0, 0);
    add(0, 32, 0, 0, 0, 8'hFE, 4'h1, 1);
    add(0, 36, 0, 0, 0, 8'hFD, 4'h2, 0);
    add(0, 40, 0, 0, 0, 8'hFB, 4'h3, 0);
    add(0, 44, 0, 0, 0, 8'hF7, 4'h4, 0);
    add(0, 48, 0, 0, 0, 8'hEF, 4'h5, 0);
    add(0, 52, 0, 0, 0, 8'hDF, 4'h6, 0);
    add(0, 56, 0, 0, 0, 8'hBF, 4'h7, 0);
    add(0, 60, 0, 0, 0, 8'h7F, 4'h8, 0);
    add(0, 64, 0, 0, 0, 8'hFE, 4'h1, 1);
    // Two loads before a wrap: last one wins
    add(1,  0, 0, 0, 0, 8'hFE, 4'h0, 0);
    add(0,  4, 1, 32'h11111111, 0, 8'hFD, 4'h0, 0);
    add(0,  8, 1, 32'h22222222, 0, 8'hFB, 4'h0, 0);
    add(0, 31, 0, 0, 0, 8'h7F, 4'h0, 0);
    add(0, 32, 0, 0, 0, 8'hFE, 4'h2, 1);
    add(0, 36, 0, 0, 0, 8'hFD, 4'h2, 0);
    add(0, 48, 0, 0, 0, 8'hEF, 4'h2, 0);
    add(0, 60, 0, 0, 0, 8'h7F, 4'h2, 0);
    add(0, 64, 0, 0, 0, 8'hFE, 4'h2, 1);
    // Load on the wrap tick overrides an older pending value, no frame delay
    add(1,  0, 0, 0, 0, 8'hFE, 4'h0, 0);
    add(0, 10, 1, 32'h33333333, 0, 8'hFB, 4'h0, 0);
    add(0, 31, 1, 32'hA5A5A5A5, 0, 8'h7F, 4'h0, 0);
    add(0, 32, 0, 0, 0, 8'hFE, 4'h5, 1);
    add(0, 33, 0, 0, 0, 8'hFE, 4'h5, 0);
    add(0, 36, 0, 0, 0, 8'hFD, 4'hA, 0);
    add(0, 40, 0, 0, 0, 8'hFB, 4'h5, 0);
    add(0, 60, 0, 0, 0, 8'h7F, 4'hA, 0);
    add(0, 64, 0, 0, 0, 8'hFE, 4'h5, 1);
    // Leading-zero blanking, latched only at the wrap
    add(1,  0, 0, 0, 0, 8'hFE, 4'h0, 0);
    add(0,  2, 0, 0, 1, 8'hFE, 4'h0, 0);
    add(0,  4, 0, 0, 1, 8'hFD, 4'h0, 0);
    add(0, 28, 0, 0, 1, 8'h7F, 4'h0, 0);
    add(0, 31, 1, 32'h00000305, 1, 8'h7F, 4'h0, 0);
    add(0, 32, 0, 0, 1, 8'hFE, 4'h5, 1);
    add(0, 36, 0, 0, 1, 8'hFD, 4'h0, 0);
    add(0, 40, 0, 0, 1, 8'hFB, 4'h3, 0);
    add(0, 44, 0, 0, 1, 8'hFF, 4'h0, 0);
    add(0, 60, 0, 0, 1, 8'hFF, 4'h0, 0);
    add(0, 63, 1, 32'h00000000, 1, 8'hFF, 4'h0, 0);
    add(0, 64, 0, 0, 1, 8'hFE, 4'h0, 1);
    add(0, 68, 0, 0, 1, 8'hFF, 4'h0, 0);
    add(0, 92, 0, 0, 1, 8'hFF, 4'h0, 0);
    add(0, 96, 0, 0, 1, 8'hFE, 4'h0, 1);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      while (cyc < vecs[i].cyc) tick_edge();
      chk($sformatf("v%0d c%0d anode", i, cyc), 32'(oAnode), 32'(vecs[i].an));
      chk($sformatf("v%0d c%0d digit", i, cyc), 32'(oDigit), 32'(vecs[i].dg));
      chk($sformatf("v%0d c%0d frame", i, cyc), 32'(oFrame), 32'(vecs[i].fr));
      iBlankLZ = vecs[i].blz;
      if (vecs[i].ld) begin
        iLoad = 1'b1;
        iData = vecs[i].data;
      end
    end

    // Mid-frame reset at idx 5 with a load pending
    do_reset();
    while (cyc < 20) tick_edge();
    iLoad = 1'b1;
    iData = 32'h99999999;
    tick_edge();
    tick_edge();
    chk("prerst anode", 32'(oAnode), 32'h000000DF);
    #2;
    iRst_n = 1'b0;
    #1;
    chk("rst anode", 32'(oAnode), 32'h000000FE);
    chk("rst digit", 32'(oDigit), 32'h0);
    chk("rst frame", 32'(oFrame), 32'h0);
    @(negedge iClk);
    iRst_n = 1'b1;
    #1;
    cyc = 0;
    for (int k = 0; k < 70; k++) begin
      tick_edge();
      chk($sformatf("postrst c%0d digit", cyc), 32'(oDigit), 32'h0);
      if (cyc == 3)  chk("postrst c3 anode", 32'(oAnode), 32'h000000FE);
      if (cyc == 4)  chk("postrst c4 anode", 32'(oAnode), 32'h000000FD);
      if (cyc == 31) chk("postrst c31 frame", 32'(oFrame), 32'h0);
      if (cyc == 32) chk("postrst c32 frame", 32'(oFrame), 32'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
